// File: rtl/bus_arbiter_4_pkg.sv
// Shared types and helpers for the 4-way round-robin bus arbiter.
// State encodings, requester count, grant encoding and the rotating priority search.
package bus_arbiter_4_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic logic [NUM_REQ-1:0] onehot2(input logic [1:0] idx);
        onehot2 = 4'b0001 << idx;
    endfunction

    // Returns {found, index}; scans start, start+1, ... mod 4 and keeps the first hit.
    function automatic logic [2:0] rr_search(input logic [NUM_REQ-1:0] req,
                                             input logic [1:0]         start);
        logic [1:0] idx;
        rr_search = 3'b000;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) rr_search = {1'b1, idx};
        end
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Enabled 4:1 word mux; output is zero while disabled.
// Purely combinational, no backpressure.
module mux_4to1 #(
    parameter int WIDTH = 16
) (
    input  logic             en_i,
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        if (en_i) begin
            case (sel_i)
                2'd0:    y_o = a_i;
                2'd1:    y_o = b_i;
                2'd2:    y_o = c_i;
                default: y_o = d_i;
            endcase
        end
    end

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter for one shared internal bus with bounded tenure (MAX_HOLD cycles).
// Grant one cycle after request; registered bus word one cycle after grant; owner may drop req anytime.
module bus_arbiter_4
    import bus_arbiter_4_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [WIDTH-1:0]   data_a_i,
    input  logic [WIDTH-1:0]   data_b_i,
    input  logic [WIDTH-1:0]   data_c_i,
    input  logic [WIDTH-1:0]   data_d_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [1:0]         owner_o,
    output logic               busy_o,
    output logic [WIDTH-1:0]   bus_data_o,
    output logic               bus_valid_o
);

    localparam int             CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0]  HOLD_ONE = CW'(1);

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CW-1:0]      hold_q, hold_d;
    logic [WIDTH-1:0]   bus_data_q;
    logic               bus_valid_q;

    logic [2:0]         pick;
    logic               grant_now;
    logic               busy;
    logic               take;
    logic [WIDTH-1:0]   mux_y;

    assign busy = (state_q == ST_GRANT);
    assign take = busy & req_i[owner_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_now = 1'b0;
        pick      = rr_search(req_i, ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (pick[2]) grant_now = 1'b1;
            end
            default: begin
                if (!req_i[owner_q]) begin
                    if (pick[2]) begin
                        grant_now = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_MAX) begin
                    // Owner is still requesting, so this search always finds someone;
                    // starting past the owner makes it compete last.
                    pick      = rr_search(req_i, owner_q + 2'd1);
                    grant_now = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
        endcase
        if (grant_now) begin
            state_d = ST_GRANT;
            owner_d = pick[1:0];
            ptr_d   = pick[1:0] + 2'd1;
            hold_d  = HOLD_ONE;
            gnt_d   = onehot2(pick[1:0]);
        end
    end

    mux_4to1 #(.WIDTH(WIDTH)) u_mux (
        .en_i  (busy),
        .sel_i (owner_q),
        .a_i   (data_a_i),
        .b_i   (data_b_i),
        .c_i   (data_c_i),
        .d_i   (data_d_i),
        .y_o   (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            bus_valid_q <= take;
            if (take) bus_data_q <= mux_y;
        end
    end

    assign gnt_o       = gnt_q;
    assign owner_o     = owner_q;
    assign busy_o      = busy;
    assign bus_data_o  = bus_data_q;
    assign bus_valid_o = bus_valid_q;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed and randomized bench for bus_arbiter_4 against a cycle-level behavioural model.
module tb_bus_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] data_a, data_b, data_c, data_d;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] bus_data;
    logic        bus_valid;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_busy;
    int          m_owner, m_ptr, m_cnt;
    bit          m_valid;
    logic [15:0] m_data;

    bus_arbiter_4 #(.WIDTH(16), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .data_a_i    (data_a),
        .data_b_i    (data_b),
        .data_c_i    (data_c),
        .data_d_i    (data_d),
        .gnt_o       (gnt),
        .owner_o     (owner),
        .busy_o      (busy),
        .bus_data_o  (bus_data),
        .bus_valid_o (bus_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word(input int i);
        case (i)
            0:       return data_a;
            1:       return data_b;
            2:       return data_c;
            default: return data_d;
        endcase
    endfunction

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_valid = 0; m_data = '0;
    endtask

    task automatic model_grant(input int w);
        m_busy = 1; m_owner = w; m_ptr = (w + 1) % 4; m_cnt = 1;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int w;
        if (m_busy && r[m_owner]) begin
            m_valid = 1;
            m_data  = word(m_owner);
        end else begin
            m_valid = 0;
        end
        if (!m_busy) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
        end else if (!r[m_owner]) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
            else begin m_busy = 0; m_cnt = 0; end
        end else if (m_cnt == MAX_HOLD) begin
            model_grant(pick(r, (m_owner + 1) % 4));
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check_all();
        chk("gnt",       32'(gnt),       m_busy ? 32'(1 << m_owner) : 32'd0);
        chk("owner",     32'(owner),     32'(m_owner));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("bus_valid", 32'(bus_valid), 32'(m_valid));
        chk("bus_data",  32'(bus_data),  32'(m_data));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    // Drive req, take one clock edge, advance the model, then compare just after the edge.
    task automatic cyc(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt",   32'(gnt),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_data",  32'(bus_data),  32'd0);
        chk("rst_owner", 32'(owner),     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req = 4'hF;
        data_a = 16'h1111; data_b = 16'h2222; data_c = 16'hBEEF; data_d = 16'h4444;
        model_reset();
        #2;
        do_reset();

        // Single requester
        cyc(4'b0100);
        chk("single_gnt",   32'(gnt),   32'h4);
        chk("single_owner", 32'(owner), 32'd2);
        cyc(4'b0100);
        chk("single_valid", 32'(bus_valid), 32'd1);
        chk("single_data",  32'(bus_data),  32'hBEEF);
        cyc(4'b0000);
        chk("single_drop_gnt", 32'(gnt), 32'd0);
        cyc(4'b0000);

        // Full contention from a fresh pointer: tenures of MAX_HOLD rotating 0,1,2,3,0
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            cyc(4'hF);
            chk("rotate_owner", 32'(owner), 32'(((k - 1) / MAX_HOLD) % 4));
        end

        // Release handover with no idle bubble
        do_reset();
        cyc(4'b0010);
        cyc(4'b1010);
        cyc(4'b1010);
        chk("handover_pre", 32'(gnt), 32'h2);
        cyc(4'b1000);
        chk("handover_gnt",  32'(gnt),  32'h8);
        chk("handover_busy", 32'(busy), 32'd1);

        // Sole requester keeps the bus across expiries
        for (int k = 1; k <= 20; k++) begin
            cyc(4'b0001);
            chk("sole_gnt", 32'(gnt), 32'h1);
            if (k >= 2) chk("sole_valid", 32'(bus_valid), 32'd1);
        end

        // Reset during a tenure, then pointer restarts at 0
        cyc(4'b0000);
        cyc(4'b0100);
        cyc(4'b0100);
        cyc(4'b0100);
        do_reset();
        cyc(4'hF);
        chk("post_rst_gnt", 32'(gnt), 32'h1);

        // Randomized traffic with sticky requests
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            data_a = 16'($urandom);
            data_b = 16'($urandom);
            data_c = 16'($urandom);
            data_d = 16'($urandom);
            cyc(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
